disp_sched: RTL and testbench

DISP_SCHED -- requirements
Module: disp_sched

---
 rtl/disp_sched.sv | 153 +++++++++++++++
 tb/tb_disp_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_sched.sv
// disp_sched: credit-based dispense scheduler with two-panel round-robin arbitration and a WAIT watchdog.
// Optional leftover-credit refund state is built only when DISP_SCHED_REFUND_EN is defined.
module disp_sched #(
   parameter int unsigned PRICE   = 4,
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic       clk,
   input  logic       areset,
   input  logic       req0,
   input  logic       req1,
   input  logic [3:0] sel0,
   input  logic [3:0] sel1,
   input  logic       coin_valid,
   input  logic [2:0] coin_val,
   input  logic       disp_done,
   input  logic       fault_clr,
   output logic       gnt0,
   output logic       gnt1,
   output logic       disp_start,
   output logic [3:0] disp_sel,
   output logic [7:0] credit,
   output logic       busy,
   output logic       err,
   output logic       refund_pulse
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GRANT = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4,
      S_FAULT = 3'd5
`ifdef DISP_SCHED_REFUND_EN
      , S_REFUND = 3'd6
`endif
   } state_t;

   localparam logic signed [10:0] PRICE_S  = 11'(PRICE);
   localparam logic        [15:0] TIMER_MAX = 16'(TIMEOUT - 1);

   state_t             state_q, state_d;
   logic        [7:0]  credit_q, credit_d;
   logic        [15:0] timer_q, timer_d;
   logic        [3:0]  sel_q;
   logic               prio_q;
   logic               win;
   logic               gnt0_q, gnt1_q, start_q, busy_q, err_q;
   logic signed [10:0] adj;
   logic signed [10:0] net;
   logic        [2:0]  coin_add;
   logic               grant_now;
`ifdef DISP_SCHED_REFUND_EN
   logic               refund_q;
`endif

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      adj      = '0;
      // prio_q names the panel that wins a tie; a lone requester always wins
      win      = (req0 && req1) ? prio_q : req1;
      coin_add = coin_valid ? coin_val : 3'd0;
      case (state_q)
         S_IDLE:  if ((credit_q >= 8'(PRICE)) && (req0 || req1)) state_d = S_GRANT;
         S_GRANT: state_d = S_START;
         S_START: begin
            adj     = -PRICE_S;
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (disp_done) begin
               state_d = S_DONE;
            end else if (timer_q == TIMER_MAX) begin
               state_d = S_FAULT;
               adj     = PRICE_S;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
`ifdef DISP_SCHED_REFUND_EN
         S_DONE:   state_d = (credit_q != 8'd0) ? S_REFUND : S_IDLE;
         S_FAULT:  if (fault_clr) state_d = (credit_q != 8'd0) ? S_REFUND : S_IDLE;
         S_REFUND: adj = -11'sd1;
`else
         S_DONE:   state_d = S_IDLE;
         S_FAULT:  if (fault_clr) state_d = S_IDLE;
`endif
         default:  state_d = S_IDLE;
      endcase

      // coin and deduction/restore are netted before saturating
      net = $signed({3'b000, credit_q}) + $signed({8'd0, coin_add}) + adj;
      if (net < 11'sd0)        credit_d = 8'd0;
      else if (net > 11'sd255) credit_d = 8'd255;
      else                     credit_d = net[7:0];

`ifdef DISP_SCHED_REFUND_EN
      if ((state_q == S_REFUND) && (credit_d == 8'd0)) state_d = S_IDLE;
`endif
   end

   assign grant_now = (state_q == S_IDLE) && (state_d == S_GRANT);

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q  <= S_IDLE;
         credit_q <= '0;
         timer_q  <= '0;
         sel_q    <= '0;
         prio_q   <= 1'b0;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         start_q  <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
`ifdef DISP_SCHED_REFUND_EN
         refund_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         timer_q  <= timer_d;
         gnt0_q   <= grant_now && !win;
         gnt1_q   <= grant_now && win;
         if (grant_now) begin
            sel_q  <= win ? sel1 : sel0;
            prio_q <= ~win;
         end
         start_q  <= (state_d == S_START);
         busy_q   <= (state_d != S_IDLE);
         err_q    <= (state_d == S_FAULT);
`ifdef DISP_SCHED_REFUND_EN
         refund_q <= (state_d == S_REFUND);
`endif
      end
   end

   assign gnt0       = gnt0_q;
   assign gnt1       = gnt1_q;
   assign disp_start = start_q;
   assign disp_sel   = sel_q;
   assign credit     = credit_q;
   assign busy       = busy_q;
   assign err        = err_q;
`ifdef DISP_SCHED_REFUND_EN
   assign refund_pulse = refund_q;
`else
   assign refund_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_disp_sched.sv
// Testbench for disp_sched: directed scenarios plus randomized transactions checked against a
// transaction-level credit/arbitration model. Honors DISP_SCHED_REFUND_EN when defined.
module tb_disp_sched;

   localparam int PRICE   = 4;
   localparam int TIMEOUT = 10;

   logic       clk = 1'b0;
   logic       areset;
   logic       req0, req1;
   logic [3:0] sel0, sel1;
   logic       coin_valid;
   logic [2:0] coin_val;
   logic       disp_done, fault_clr;
   logic       gnt0, gnt1, disp_start, busy, err, refund_pulse;
   logic [3:0] disp_sel;
   logic [7:0] credit;

   int checks = 0;
   int errors = 0;
   int mc     = 0;   // model credit
   int last_w = 1;   // panel granted last; 1 gives panel 0 the first tie

   disp_sched #(.PRICE(PRICE), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .areset(areset), .req0(req0), .req1(req1), .sel0(sel0), .sel1(sel1),
      .coin_valid(coin_valid), .coin_val(coin_val), .disp_done(disp_done), .fault_clr(fault_clr),
      .gnt0(gnt0), .gnt1(gnt1), .disp_start(disp_start), .disp_sel(disp_sel), .credit(credit),
      .busy(busy), .err(err), .refund_pulse(refund_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int clamp(input int v);
      return (v < 0) ? 0 : ((v > 255) ? 255 : v);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_credit"}, credit, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_gnt"}, {gnt0, gnt1}, 0);
      chk({tag, "_start"}, disp_start, 0);
      chk({tag, "_sel"}, disp_sel, 0);
      chk({tag, "_refund"}, refund_pulse, 0);
   endtask

   task automatic add_coin(input int v);
      coin_valid = 1'b1;
      coin_val   = 3'(v);
      step();
      coin_valid = 1'b0;
      mc = clamp(mc + v);
      chk("coin_credit", credit, mc);
   endtask

   // Return to IDLE, counting refund pulses when the refund build is active.
   task automatic settle_idle();
`ifdef DISP_SCHED_REFUND_EN
      int cnt = 0;
      int k   = 0;
      while (busy === 1'b1 && k < 300) begin
         if (refund_pulse === 1'b1) cnt++;
         step();
         k++;
      end
      chk("refund_cnt", cnt, mc);
      mc = 0;
`endif
      chk("idle_busy", busy, 0);
      chk("idle_credit", credit, mc);
   endtask

   // One request/dispense transaction. d = WAIT cycle of disp_done (>= TIMEOUT means never).
   task automatic do_txn(input int rmask, input int s0, input int s1, input int cvg,
                         input int cvs, input int d, input int wc);
      int w, v, eff, h;
      bit fin;
      req0 = rmask[0];
      req1 = rmask[1];
      sel0 = 4'(s0);
      sel1 = 4'(s1);
      if (mc < PRICE) begin
         repeat (3) begin
            step();
            chk("nogrant_gnt", {gnt0, gnt1}, 0);
            chk("nogrant_busy", busy, 0);
         end
         req0 = 1'b0;
         req1 = 1'b0;
         return;
      end
      w = (rmask == 3) ? (1 - last_w) : ((rmask == 2) ? 1 : 0);
      last_w = w;
      step();
      chk("gnt0", gnt0, (w == 0));
      chk("gnt1", gnt1, (w == 1));
      chk("grant_busy", busy, 1);
      chk("grant_nostart", disp_start, 0);
      req0 = 1'b0;
      req1 = 1'b0;
      coin_valid = (cvg != 0);
      coin_val   = 3'(cvg);
      step();
      mc = clamp(mc + cvg);
      sel0 = 4'($urandom_range(0, 15));
      sel1 = 4'($urandom_range(0, 15));
      chk("start_strobe", disp_start, 1);
      chk("start_gnt_low", {gnt0, gnt1}, 0);
      chk("start_sel", disp_sel, (w == 1) ? s1 : s0);
      chk("start_credit", credit, mc);
      coin_valid = (cvs != 0);
      coin_val   = 3'(cvs);
      step();
      mc = clamp(mc + cvs - PRICE);
      chk("wait_credit", credit, mc);
      chk("wait_nostart", disp_start, 0);
      fin = 1'b0;
      for (int i = 0; i < TIMEOUT && !fin; i++) begin
         v = (wc > 0) ? $urandom_range(0, wc) : 0;
         coin_valid = (wc > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         coin_val   = 3'(v);
         eff        = coin_valid ? v : 0;
         disp_done  = (i == d);
         step();
         disp_done  = 1'b0;
         coin_valid = 1'b0;
         if (i == d) begin
            mc = clamp(mc + eff);
            chk("done_busy", busy, 1);
            chk("done_err", err, 0);
            chk("done_credit", credit, mc);
            fin = 1'b1;
         end else if (i == TIMEOUT - 1) begin
            mc = clamp(mc + eff + PRICE);
            chk("fault_err", err, 1);
            chk("fault_credit", credit, mc);
            fin = 1'b1;
         end else begin
            mc = clamp(mc + eff);
            chk("wait_err", err, 0);
            chk("wait_sel_held", disp_sel, (w == 1) ? s1 : s0);
         end
      end
      if (err === 1'b1) begin
         h = $urandom_range(0, 3);
         repeat (h) begin
            step();
            chk("fault_hold", err, 1);
         end
         fault_clr = 1'b1;
         step();
         fault_clr = 1'b0;
         chk("fault_clr_err", err, 0);
      end else begin
         step();
      end
      settle_idle();
   endtask

   initial begin
      int r, n;
      areset = 1'b1;
      {req0, req1, coin_valid, disp_done, fault_clr} = '0;
      sel0 = '0; sel1 = '0; coin_val = '0;
      #12;
      check_all_zero("reset");
      @(negedge clk);
      areset = 1'b0;
      step();
      check_all_zero("post_reset");

      // both panels held with credit 8: panel 0 then panel 1
      add_coin(7);
      add_coin(1);
      do_txn(3, 2, 11, 0, 0, 2, 0);
      do_txn(3, 3, 12, 0, 0, 0, 0);
      chk("rr_credit0", credit, 0);

      // basic dispense: 3+1 credits, panel 0 selection 5
      add_coin(3);
      add_coin(1);
      do_txn(1, 5, 0, 0, 0, 3, 0);

      // insufficient credit, then one more coin releases the held request
      add_coin(3);
      do_txn(2, 0, 9, 0, 0, 1, 0);
      req1 = 1'b1;
      sel1 = 4'd9;
      add_coin(1);
      chk("low_credit_gnt1", gnt1, 0);
      do_txn(2, 0, 9, 0, 0, 1, 0);

      // watchdog: no disp_done within TIMEOUT
      add_coin(4);
      do_txn(1, 7, 0, 0, 0, TIMEOUT, 0);

      // saturation: 254 + 7 - 4 nets to 257, clamps to 255
      while (mc + 7 <= 254) add_coin(7);
      if (mc < 254) add_coin(254 - mc);
      do_txn(1, 1, 0, 0, 7, 1, 0);

      // asynchronous reset in WAIT abandons the transaction; round-robin returns to panel 0
      if (mc < PRICE) add_coin(PRICE);
      req0 = 1'b1;
      sel0 = 4'd6;
      step();
      req0 = 1'b0;
      step();
      step();
      #2;
      areset = 1'b1;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      areset = 1'b0;
      mc = 0;
      last_w = 1;
      step();
      add_coin(5);
      do_txn(3, 4, 8, 0, 0, 0, 0);

`ifdef DISP_SCHED_REFUND_EN
      // credit 6 leaves 2 units to refund after one dispense
      while (mc < 6) add_coin(6 - mc);
      if (mc == 6) do_txn(1, 2, 0, 0, 0, 2, 0);
`endif

      for (int it = 0; it < 40; it++) begin
         n = $urandom_range(0, 3);
         repeat (n) add_coin($urandom_range(0, 7));
         r = ($urandom_range(0, 4) == 0) ? TIMEOUT : $urandom_range(0, TIMEOUT - 1);
         do_txn($urandom_range(1, 3), $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 7), $urandom_range(0, 7), r, 7);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
